merge_bank_scheduler: RTL and testbench

Controller that sequences the sprite/background merge datapath and its ping-pong 16-pixel output banks (A/B) against the VGA reader. It collects all sprite anchor positions before merging starts. It then paces merged-pixel writes into the bank the VGA is not reading and swaps banks on VGA demand. It flags underruns and signals end of frame.

---
 rtl/merge_bank_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_merge_bank_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_bank_scheduler.sv
// Sequencer for the sprite/background merge path: captures sprite anchors, primes bank A,
// then ping-pongs 16-pixel banks A/B against the VGA reader, flagging underruns.
module merge_bank_scheduler #(
  parameter int NUM_SPRITES  = 32,
  parameter int PIX_PER_BANK = 16,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       anc_valid,
  output logic       anc_ready,
  output logic [4:0] anc_idx,
  output logic       anc_we,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       wr_en,
  output logic       wr_bank,
  output logic [3:0] wr_idx,
  output logic       rd_bank,
  input  logic       vga_bank_done,
  output logic       vga_start,
  output logic       full_a,
  output logic       full_b,
  output logic       underrun,
  output logic       frame_done,
  output logic       busy
);

  localparam int ANC_W       = 5;
  localparam int PIX_W       = 4;
  localparam int BANK_W      = 15;
  localparam int FRAME_BANKS = FRAME_PIXELS / PIX_PER_BANK;

  localparam logic [ANC_W-1:0]  ANC_LAST   = ANC_W'(NUM_SPRITES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(PIX_PER_BANK - 1);
  localparam logic [BANK_W-1:0] BANKS_ALL  = BANK_W'(FRAME_BANKS);
  localparam logic [BANK_W-1:0] BANKS_LAST = BANK_W'(FRAME_BANKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [ANC_W-1:0]   anc_idx_q, anc_idx_d;
  logic [PIX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               rd_bank_q, rd_bank_d;
  logic               full_a_q, full_a_d;
  logic               full_b_q, full_b_d;
  logic               underrun_q, underrun_d;
  logic               vga_start_q, vga_start_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic [BANK_W-1:0]  banks_wr_q, banks_wr_d;
  logic [BANK_W-1:0]  banks_rd_q, banks_rd_d;

  logic wr_full;
  logic wr_last;
  logic writing_state;

  // Write bank is always the one VGA is not reading: rd_bank=1 means A is being written.
  assign wr_bank       = ~rd_bank_q;
  assign wr_full       = rd_bank_q ? full_a_q : full_b_q;
  assign writing_state = (state_q == S_PRIME) || (state_q == S_STREAM);

  assign anc_ready = (state_q == S_LOAD);
  assign anc_we    = anc_valid & anc_ready;
  assign pix_ready = writing_state && !wr_full && (banks_wr_q < BANKS_ALL);
  assign wr_en     = pix_valid & pix_ready;
  assign wr_last   = wr_en && (wr_idx_q == PIX_LAST);

  always_comb begin
    state_d      = state_q;
    anc_idx_d    = anc_idx_q;
    wr_idx_d     = wr_idx_q;
    rd_bank_d    = rd_bank_q;
    full_a_d     = full_a_q;
    full_b_d     = full_b_q;
    underrun_d   = underrun_q;
    banks_wr_d   = banks_wr_q;
    banks_rd_d   = banks_rd_q;
    vga_start_d  = 1'b0;
    frame_done_d = 1'b0;

    if (writing_state && wr_en) begin
      if (wr_last) begin
        wr_idx_d = '0;
        if (rd_bank_q) full_a_d = 1'b1;
        else           full_b_d = 1'b1;
        if (banks_wr_q < BANKS_ALL) banks_wr_d = banks_wr_q + 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          anc_idx_d  = '0;
          wr_idx_d   = '0;
          rd_bank_d  = 1'b1;
          full_a_d   = 1'b0;
          full_b_d   = 1'b0;
          underrun_d = 1'b0;
          banks_wr_d = '0;
          banks_rd_d = '0;
        end
      end
      S_LOAD: begin
        if (anc_we) begin
          if (anc_idx_q == ANC_LAST) begin
            anc_idx_d = '0;
            state_d   = S_PRIME;
          end else begin
            anc_idx_d = anc_idx_q + 1'b1;
          end
        end
      end
      S_PRIME: begin
        // pix_ready is already low once A is full, so no write races this handoff.
        if (full_a_q) begin
          rd_bank_d   = 1'b0;
          full_b_d    = 1'b0;
          wr_idx_d    = '0;
          vga_start_d = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (vga_bank_done) begin
          if (banks_rd_q == BANKS_LAST) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else if (wr_full || wr_last) begin
            rd_bank_d  = ~rd_bank_q;
            if (rd_bank_q) full_b_d = 1'b0;
            else           full_a_d = 1'b0;
            banks_rd_d = banks_rd_q + 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      anc_idx_q    <= '0;
      wr_idx_q     <= '0;
      rd_bank_q    <= 1'b1;
      full_a_q     <= 1'b0;
      full_b_q     <= 1'b0;
      underrun_q   <= 1'b0;
      vga_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      banks_wr_q   <= '0;
      banks_rd_q   <= '0;
    end else begin
      state_q      <= state_d;
      anc_idx_q    <= anc_idx_d;
      wr_idx_q     <= wr_idx_d;
      rd_bank_q    <= rd_bank_d;
      full_a_q     <= full_a_d;
      full_b_q     <= full_b_d;
      underrun_q   <= underrun_d;
      vga_start_q  <= vga_start_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      banks_wr_q   <= banks_wr_d;
      banks_rd_q   <= banks_rd_d;
    end
  end

  assign anc_idx    = anc_idx_q;
  assign wr_idx     = wr_idx_q;
  assign rd_bank    = rd_bank_q;
  assign full_a     = full_a_q;
  assign full_b     = full_b_q;
  assign underrun   = underrun_q;
  assign vga_start  = vga_start_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_merge_bank_scheduler.sv
// Scoreboard bench for merge_bank_scheduler with a 4-bank frame (64 pixels).
module tb_merge_bank_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       anc_valid = 1'b0;
  logic       pix_valid = 1'b0;
  logic       vga_bank_done = 1'b0;
  logic       anc_ready, anc_we, pix_ready, wr_en, wr_bank, rd_bank;
  logic       vga_start, full_a, full_b, underrun, frame_done, busy;
  logic [4:0] anc_idx;
  logic [3:0] wr_idx;

  merge_bank_scheduler #(
    .NUM_SPRITES(32), .PIX_PER_BANK(16), .FRAME_PIXELS(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .anc_valid(anc_valid), .anc_ready(anc_ready), .anc_idx(anc_idx), .anc_we(anc_we),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_idx(wr_idx), .rd_bank(rd_bank),
    .vga_bank_done(vga_bank_done), .vga_start(vga_start),
    .full_a(full_a), .full_b(full_b), .underrun(underrun),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int EV_START = 1;
  localparam int EV_DONE  = 2;

  int         n_vec = 0;
  int         n_err = 0;
  int         wr_cnt = 0;
  logic [4:0] exp_anc[$];
  logic [4:0] exp_wr[$];
  int         exp_evt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] outs();
    return {anc_ready, anc_idx, anc_we, pix_ready, wr_en, wr_idx, rd_bank, wr_bank,
            vga_start, full_a, full_b, underrun, frame_done, busy};
  endfunction

  // Only rd_bank (bit 7) is 1 in the reset state.
  localparam logic [20:0] RESET_OUTS = 21'h000080;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    vga_bank_done = 1'b1;
    tick();
    vga_bank_done = 1'b0;
  endtask

  task automatic push_frame_wr();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++)
        exp_wr.push_back({b[0], i[3:0]});
  endtask

  task automatic load_anchors(input bit gaps);
    for (int i = 0; i < 32; i++) exp_anc.push_back(i[4:0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      if (gaps && b != 0 && (b % 8) == 0) begin
        anc_valid = 1'b0;
        tick();
        tick();
      end
      anc_valid = 1'b1;
      tick();
    end
    anc_valid = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (vga_start) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL vga_start_timeout: got no pulse expected pulse within 80 cycles");
    end
  endtask

  // Monitor: every DUT output event is matched against the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (anc_we) begin
        if (exp_anc.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL anc_unexpected: got anc_we idx %0d expected no beat", anc_idx);
        end else chk("anc_idx", 32'(anc_idx), 32'(exp_anc.pop_front()));
      end
      if (wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wr_unexpected: got write bank %0d idx %0d expected none", wr_bank, wr_idx);
        end else chk("wr_bank_idx", 32'({wr_bank, wr_idx}), 32'(exp_wr.pop_front()));
      end
      if (vga_start) begin
        if (exp_evt.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL start_unexpected: got vga_start expected none");
        end else chk("evt_vga_start", EV_START, 32'(exp_evt.pop_front()));
      end
      if (frame_done) begin
        if (exp_evt.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done_unexpected: got frame_done expected none");
        end else chk("evt_frame_done", EV_DONE, 32'(exp_evt.pop_front()));
      end
    end
  end

  initial begin
    // Reset held: inputs toggling must not disturb reset values.
    for (int i = 0; i < 4; i++) begin
      start = i[0]; anc_valid = ~i[0]; pix_valid = i[1]; vga_bank_done = i[0];
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'(RESET_OUTS));
      tick();
    end
    start = 0; anc_valid = 0; pix_valid = 0; vga_bank_done = 0;
    reset = 1'b1;
    repeat (3) tick();
    pix_valid = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_pix_ready", 32'(pix_ready), 0);
    pix_valid = 1'b0;
    tick();

    // Frame 1: gapped anchor load, then a clean 4-bank frame.
    push_frame_wr();
    exp_evt.push_back(EV_START);
    exp_evt.push_back(EV_DONE);
    wr_cnt = 0;
    load_anchors(1'b1);
    anc_valid = 1'b1;
    pix_valid = 1'b1;
    @(negedge clk);
    chk("extra_anc_ready", 32'(anc_ready), 0);
    chk("prime_busy", 32'(busy), 1);
    anc_valid = 1'b0;
    wait_start();
    chk("rd_after_prime", 32'(rd_bank), 0);
    for (int s = 0; s < 3; s++) begin
      repeat (20) tick();
      done_pulse();
      @(negedge clk);
      chk("rd_swap", 32'(rd_bank), 32'((s % 2) == 0));
    end
    repeat (20) tick();
    done_pulse();
    @(negedge clk);
    chk("f1_frame_done", 32'(frame_done), 1);
    chk("f1_busy_at_done", 32'(busy), 0);
    chk("f1_underrun", 32'(underrun), 0);
    chk("f1_rd_no_swap", 32'(rd_bank), 1);
    chk("f1_wr_count", 32'(wr_cnt), 64);
    tick();
    @(negedge clk);
    chk("f1_done_one_cycle", 32'(frame_done), 0);
    pix_valid = 1'b0;

    // Frame 2: backpressure, simultaneous done, underrun.
    push_frame_wr();
    exp_evt.push_back(EV_START);
    wr_cnt = 0;
    pix_valid = 1'b1;
    load_anchors(1'b0);
    wait_start();
    repeat (30) tick();
    @(negedge clk);
    chk("bp_pix_ready", 32'(pix_ready), 0);
    chk("bp_wr_count", 32'(wr_cnt), 32);
    chk("bp_full_ab", 32'({full_a, full_b}), 3);
    pix_valid = 1'b0;
    done_pulse();
    @(negedge clk);
    chk("bp_swap_rd", 32'(rd_bank), 1);
    chk("bp_release_a", 32'(full_a), 0);

    pix_valid = 1'b1;
    repeat (15) tick();
    vga_bank_done = 1'b1;
    tick();
    vga_bank_done = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("sim_swap_rd", 32'(rd_bank), 0);
    chk("sim_underrun", 32'(underrun), 0);
    chk("sim_full_ab", 32'({full_a, full_b}), 2);

    pix_valid = 1'b1;
    repeat (5) tick();
    pix_valid = 1'b0;
    @(negedge clk);
    chk("ur_wr_idx", 32'(wr_idx), 5);
    done_pulse();
    @(negedge clk);
    chk("ur_underrun", 32'(underrun), 1);
    chk("ur_rd_hold", 32'(rd_bank), 0);
    pix_valid = 1'b1;
    repeat (11) tick();
    pix_valid = 1'b0;
    @(negedge clk);
    chk("ur_full_b", 32'(full_b), 1);
    chk("ur_pix_ready", 32'(pix_ready), 0);
    done_pulse();
    @(negedge clk);
    chk("ur_later_swap", 32'(rd_bank), 1);
    chk("ur_sticky", 32'(underrun), 1);
    chk("f2_wr_count", 32'(wr_cnt), 64);

    // Reset mid-STREAM, then a fresh start reloads anchors from slot 0.
    reset = 1'b0;
    #1;
    chk("midreset_outs", 32'(outs()), 32'(RESET_OUTS));
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) exp_anc.push_back(i[4:0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("f3_underrun_clr", 32'(underrun), 0);
    chk("f3_busy", 32'(busy), 1);
    chk("f3_anc_idx0", 32'(anc_idx), 0);
    anc_valid = 1'b1;
    repeat (3) tick();
    anc_valid = 1'b0;
    @(negedge clk);
    chk("f3_anc_idx3", 32'(anc_idx), 3);

    chk("anc_queue_drained", 32'(exp_anc.size()), 0);
    chk("wr_queue_drained", 32'(exp_wr.size()), 0);
    chk("evt_queue_drained", 32'(exp_evt.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
